// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per clock, with saturation on overflow.
// Optional leading-zero mask output enabled by defining BIN2BCD_SEQ_BLANK_EN.
module bin2bcd_seq #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
`ifdef BIN2BCD_SEQ_BLANK_EN
    ,
    output logic [DIGITS-1:0]     blank
`endif
);

    // Decimal digits needed for the largest BIN_W-bit value, never fewer than DIGITS.
    function automatic int acc_digits(input int w, input int d);
        logic [63:0] v;
        int          n;
        v = (64'd1 << w) - 64'd1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (v != 64'd0) begin
                v = v / 64'd10;
                n++;
            end
        end
        return (n > d) ? n : d;
    endfunction

    function automatic logic [63:0] pow10(input int d);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < d; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    localparam int          ACC_D   = acc_digits(BIN_W, DIGITS);
    localparam int          ACC_W   = 4 * ACC_D;
    localparam int          OUT_W   = 4 * DIGITS;
    localparam int          CNT_W   = (BIN_W > 2) ? $clog2(BIN_W) : 2;
    localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t             state;
    state_t             next_state;

    logic [ACC_W-1:0]   acc;
    logic [BIN_W-1:0]   sh;
    logic [CNT_W-1:0]   cnt;
    logic               ovf_pend;

    logic [ACC_W-1:0]   adj;
    logic [ACC_W-1:0]   acc_shift;
    logic [BIN_W-1:0]   sh_shift;
    logic [OUT_W-1:0]   result;
    logic               last_shift;
    logic               accept;

    assign accept     = (state == IDLE) && start;
    assign last_shift = (cnt == CNT_W'(BIN_W - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = SHIFT;
            SHIFT:   if (last_shift) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            SHIFT: busy = 1'b1;
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    always_comb begin
        adj = acc;
        for (int d = 0; d < ACC_D; d++) begin
            if (acc[4*d +: 4] >= 4'd5) begin
                adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
            end
        end
        acc_shift = {adj[ACC_W-2:0], sh[BIN_W-1]};
        sh_shift  = {sh[BIN_W-2:0], 1'b0};
        result    = ovf_pend ? {DIGITS{4'h9}} : acc_shift[OUT_W-1:0];
    end

    // Results are registered on the edge that enters DONE so they are valid alongside the done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            sh       <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            bcd      <= '0;
            ovf      <= 1'b0;
        end else if (accept) begin
            acc      <= '0;
            sh       <= bin;
            cnt      <= '0;
            ovf_pend <= (64'(bin) > MAX_VAL);
        end else if (state == SHIFT) begin
            acc <= acc_shift;
            sh  <= sh_shift;
            cnt <= cnt + CNT_W'(1);
            if (last_shift) begin
                bcd <= result;
                ovf <= ovf_pend;
            end
        end
    end

`ifdef BIN2BCD_SEQ_BLANK_EN
    logic [DIGITS-1:0] blank_next;
    logic              zero_above;

    always_comb begin
        blank_next = '0;
        zero_above = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_above    = zero_above && (result[4*k +: 4] == 4'd0);
            blank_next[k] = zero_above;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blank <= '1;
        end else if ((state == SHIFT) && last_shift) begin
            blank <= blank_next;
        end
    end
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq (BIN_W=14, DIGITS=4): table vectors, random vectors vs.
// an arithmetic reference, and hand-written sequences for busy-ignore, reset abort and held start.
module tb_bin2bcd_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [13:0] bin;
    logic        busy;
    logic        done;
    logic [15:0] bcd;
    logic        ovf;
`ifdef BIN2BCD_SEQ_BLANK_EN
    logic [3:0]  blank;
`endif

    int checks = 0;
    int errors = 0;

    bin2bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .ovf   (ovf)
`ifdef BIN2BCD_SEQ_BLANK_EN
        ,
        .blank (blank)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] v;
        logic [15:0] exp_bcd;
        logic        exp_ovf;
    } vec_t;

    vec_t table_v[10];

    // Decimal conversion from the value itself, saturating above four digits.
    function automatic logic [15:0] ref_bcd(input int v);
        logic [15:0] r;
        int          x;
        if (v > 9999) return 16'h9999;
        r = '0;
        x = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [3:0] ref_blank(input int v);
        logic [3:0] r;
        r = 4'b0000;
        if (v <= 9999) begin
            r[1] = (v < 10);
            r[2] = (v < 100);
            r[3] = (v < 1000);
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One full conversion: checks latency, busy throughout, result, and the single-cycle done pulse.
    task automatic applyStimulus(input logic [13:0] v, input logic [15:0] exp_bcd,
                                 input logic exp_ovf, input string name);
        int lat;
        bit seen;
        bit busy_ok;
        @(negedge clk);
        bin   = v;
        start = 1'b1;
        @(posedge clk);
        lat     = 1;
        seen    = 1'b0;
        busy_ok = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bin   = 14'($urandom);
        while (lat < 40) begin
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        checkOutput({name, " done_seen"}, 32'(seen), 32'd1);
        checkOutput({name, " latency"}, 32'(lat), 32'd15);
        checkOutput({name, " busy"}, 32'(busy_ok), 32'd1);
        checkOutput({name, " bcd"}, 32'(bcd), 32'(exp_bcd));
        checkOutput({name, " ovf"}, 32'(ovf), 32'(exp_ovf));
`ifdef BIN2BCD_SEQ_BLANK_EN
        checkOutput({name, " blank"}, 32'(blank), 32'(ref_blank(int'(v))));
`endif
        @(negedge clk);
        checkOutput({name, " done_pulse"}, 32'(done), 32'd0);
        checkOutput({name, " idle"}, 32'(busy), 32'd0);
        checkOutput({name, " bcd_hold"}, 32'(bcd), 32'(exp_bcd));
    endtask

    initial begin
        int          done_cnt;
        int          done_at[$];
        logic [15:0] first_bcd;
        logic [13:0] rv;

        table_v[0] = '{14'd9999,  16'h9999, 1'b0};
        table_v[1] = '{14'd12345, 16'h9999, 1'b1};
        table_v[2] = '{14'd0,     16'h0000, 1'b0};
        table_v[3] = '{14'd42,    16'h0042, 1'b0};
        table_v[4] = '{14'd4321,  16'h4321, 1'b0};
        table_v[5] = '{14'd16383, 16'h9999, 1'b1};
        table_v[6] = '{14'd10000, 16'h9999, 1'b1};
        table_v[7] = '{14'd1000,  16'h1000, 1'b0};
        table_v[8] = '{14'd1,     16'h0001, 1'b0};
        table_v[9] = '{14'd5678,  16'h5678, 1'b0};

        rst   = 1'b1;
        start = 1'b0;
        bin   = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset bcd", 32'(bcd), 32'd0);
        checkOutput("reset ovf", 32'(ovf), 32'd0);
`ifdef BIN2BCD_SEQ_BLANK_EN
        checkOutput("reset blank", 32'(blank), 32'hF);
`endif
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(table_v[i].v, table_v[i].exp_bcd, table_v[i].exp_ovf, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 25; i++) begin
            rv = 14'($urandom_range(0, 16383));
            applyStimulus(rv, ref_bcd(int'(rv)), (rv > 14'd9999), $sformatf("rand%0d(%0d)", i, rv));
        end

        // A second start during conversion must not be queued or alter the result.
        @(negedge clk);
        bin   = 14'd250;
        start = 1'b1;
        @(posedge clk);
        done_cnt  = 0;
        first_bcd = 16'hFFFF;
        done_at.delete();
        for (int c = 1; c <= 35; c++) begin
            @(negedge clk);
            start = (c == 5);
            bin   = (c == 5) ? 14'd77 : 14'($urandom);
            if (done) begin
                done_cnt++;
                done_at.push_back(c);
                if (done_cnt == 1) first_bcd = bcd;
            end
        end
        start = 1'b0;
        checkOutput("ignore done_count", 32'(done_cnt), 32'd1);
        checkOutput("ignore done_cycle", (done_at.size() > 0) ? 32'(done_at[0]) : 32'hDEAD, 32'd15);
        checkOutput("ignore bcd", 32'(first_bcd), 32'h0250);

        // Reset mid-conversion aborts without a done pulse.
        @(negedge clk);
        bin   = 14'd4321;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort bcd", 32'(bcd), 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        checkOutput("abort no_done", 32'(done_cnt), 32'd0);
        checkOutput("abort bcd_hold", 32'(bcd), 32'd0);
        applyStimulus(14'd4321, 16'h4321, 1'b0, "after_abort");

        // Start held high re-accepts every BIN_W+2 cycles.
        @(negedge clk);
        bin   = 14'd1;
        start = 1'b1;
        done_at.delete();
        done_cnt = 0;
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            if (done) begin
                done_at.push_back(c);
                if (bcd !== 16'h0001) done_cnt++;
            end
        end
        start = 1'b0;
        checkOutput("held pulses", 32'(done_at.size() >= 4), 32'd1);
        checkOutput("held bad_bcd", 32'(done_cnt), 32'd0);
        for (int i = 1; i < done_at.size(); i++) begin
            checkOutput($sformatf("held period%0d", i), 32'(done_at[i] - done_at[i-1]), 32'd16);
        end
        repeat (20) @(negedge clk);
        checkOutput("held idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
